gost89_cfb_byte_adapter: RTL and testbench

- Byte-stream front/back end for the GOST 28147-89 CFB cores (gost89_cfb_encrypt / gost89_cfb_decrypt).
- Input side: collects an 8-byte gamma (IV) and then plaintext or ciphertext bytes from a valid/ready stream. Packs them into 64-bit blocks and sequences the core's reset/load_data/busy protocol.
- Output side: serializes each 64-bit result back onto a valid/ready byte stream.
- Handles a short final block. The core instance, key and sbox sit outside this block.

---
 rtl/gost89_cfb_byte_adapter_if.sv | 27 ++
 rtl/gost89_cfb_byte_adapter.sv | 151 +++++++++++++++
 tb/tb_gost89_cfb_byte_adapter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gost89_cfb_byte_adapter_if.sv
// Byte-stream and core-side bus of the GOST 28147-89 CFB byte adapter.
// The master modport is the adapter's view; slave is the environment's (source, sink, core).
interface gost89_cfb_byte_adapter_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        core_reset;
    logic        core_load;
    logic [63:0] core_in;
    logic [63:0] core_out;
    logic        core_busy;

    modport master (
        input  s_data, s_valid, s_last, m_ready, core_out, core_busy,
        output s_ready, m_data, m_valid, m_last, core_reset, core_load, core_in
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready, core_out, core_busy,
        input  s_ready, m_data, m_valid, m_last, core_reset, core_load, core_in
    );
endinterface

// File: rtl/gost89_cfb_byte_adapter.sv
// Packs a byte stream into 64-bit blocks for a GOST 28147-89 CFB core, sequences its
// reset/load/busy protocol and serializes each result back onto a byte stream.
module gost89_cfb_byte_adapter #(
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    gost89_cfb_byte_adapter_if.master   bus,
    output logic                        busy,
    output logic                        err
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE, IV_COLLECT, IV_LOAD, DATA_COLLECT, CORE_LOAD, CORE_WAIT, EMIT
    } state_t;

    state_t         state_q;
    logic [63:0]    core_in_q;
    logic [63:0]    out_q;
    logic [2:0]     cnt_q;
    logic [2:0]     ocnt_q;
    logic [3:0]     n_q;
    logic           last_q;
    logic           m_last_q;
    logic           err_q;
    logic [TW-1:0]  tmo_q;

    logic           accept;
    logic [63:0]    shift_d;
    logic [63:0]    block_d;
    logic           emit_done_d;
    logic           m_last_d;

    // start overrides everything in its cycle: no byte taken, no strobe issued, no output offered
    assign bus.s_ready    = (state_q == IV_COLLECT || state_q == DATA_COLLECT) && !start;
    assign bus.core_reset = (state_q == IV_LOAD) && !start;
    assign bus.core_load  = (state_q == CORE_LOAD) && !start;
    assign bus.m_valid    = (state_q == EMIT) && !start;
    assign bus.m_last     = m_last_q && bus.m_valid;
    assign bus.m_data     = out_q[63:56];
    assign bus.core_in    = core_in_q;
    assign busy           = (state_q != IDLE);
    assign err            = err_q;

    assign accept      = bus.s_valid && bus.s_ready;
    assign shift_d     = {core_in_q[55:0], bus.s_data};
    // Short block: bytes collected so far sit low; move them to the top, zeros fill below
    assign block_d     = shift_d << {~cnt_q, 3'b000};
    assign emit_done_d = ({1'b0, ocnt_q} == (n_q - 4'd1));
    assign m_last_d    = last_q && (({1'b0, ocnt_q} + 4'd2) == n_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            core_in_q <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            ocnt_q    <= '0;
            n_q       <= '0;
            last_q    <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (start) begin
                state_q   <= IV_COLLECT;
                core_in_q <= '0;
                cnt_q     <= '0;
                ocnt_q    <= '0;
                m_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    IV_COLLECT: begin
                        if (accept) begin
                            core_in_q <= shift_d;
                            cnt_q     <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                state_q <= IV_LOAD;
                            end else if (bus.s_last) begin
                                err_q     <= 1'b1;
                                state_q   <= IDLE;
                                cnt_q     <= '0;
                                core_in_q <= '0;
                            end
                        end
                    end
                    IV_LOAD: begin
                        state_q   <= DATA_COLLECT;
                        core_in_q <= '0;
                        cnt_q     <= '0;
                    end
                    DATA_COLLECT: begin
                        if (accept) begin
                            if (cnt_q == 3'd7 || bus.s_last) begin
                                core_in_q <= block_d;
                                n_q       <= {1'b0, cnt_q} + 4'd1;
                                last_q    <= bus.s_last;
                                cnt_q     <= '0;
                                tmo_q     <= '0;
                                state_q   <= CORE_LOAD;
                            end else begin
                                core_in_q <= shift_d;
                                cnt_q     <= cnt_q + 3'd1;
                            end
                        end
                    end
                    CORE_LOAD: begin
                        tmo_q   <= tmo_q + TW'(1);
                        state_q <= CORE_WAIT;
                    end
                    CORE_WAIT: begin
                        tmo_q <= tmo_q + TW'(1);
                        // tmo_q == 1 is the cycle where the core may not have raised busy yet
                        if (tmo_q != TW'(1) && !bus.core_busy) begin
                            out_q    <= bus.core_out;
                            ocnt_q   <= '0;
                            m_last_q <= last_q && (n_q == 4'd1);
                            state_q  <= EMIT;
                        end else if (tmo_q == TW'(BUSY_TIMEOUT)) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    EMIT: begin
                        if (bus.m_ready) begin
                            out_q  <= out_q << 8;
                            ocnt_q <= ocnt_q + 3'd1;
                            if (emit_done_d) begin
                                m_last_q <= 1'b0;
                                if (last_q) begin
                                    state_q <= IDLE;
                                end else begin
                                    state_q   <= DATA_COLLECT;
                                    core_in_q <= '0;
                                    cnt_q     <= '0;
                                end
                            end else begin
                                m_last_q <= m_last_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gost89_cfb_byte_adapter.sv
// Directed bench for the CFB byte adapter, driving a small stub core whose block
// function is out = in ^ feedback with ciphertext feedback, so every result is hand-computable.
module tb_gost89_cfb_byte_adapter;
    localparam int BT  = 64;
    localparam int LAT = 4;

    localparam logic [63:0] IV1 = 64'h6aa0379517bb57af;
    localparam logic [63:0] P1  = 64'h8d437364581af0da;
    localparam logic [63:0] C1  = 64'he7e344f14fa1a775;
    localparam logic [63:0] P2  = 64'h12911df3eddcc0fb;
    localparam logic [63:0] C2  = 64'hf5725902a27d678e;
    localparam logic [63:0] IV2 = 64'hfa5679a45f118aed;
    localparam logic [63:0] P3  = 64'h419677a6eff07f2f;
    localparam logic [63:0] C3  = 64'hbbc00e02b0e1f5c2;
    localparam logic [63:0] PP  = 64'h12911d0000000000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, err;
    logic stuck = 1'b0;

    gost89_cfb_byte_adapter_if bus();

    gost89_cfb_byte_adapter #(.BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus.master), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stub core: busy for LAT cycles after a load, result appears only as busy falls
    logic [63:0] fb, pend;
    int          lat_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fb <= '0; pend <= '0; lat_cnt <= 0;
            bus.core_busy <= 1'b0; bus.core_out <= '0;
        end else if (bus.core_reset) begin
            fb <= bus.core_in; lat_cnt <= 0; bus.core_busy <= stuck;
        end else if (bus.core_load) begin
            pend <= bus.core_in ^ fb; lat_cnt <= LAT; bus.core_busy <= 1'b1;
            bus.core_out <= ~(bus.core_in ^ fb);
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                bus.core_busy <= stuck; bus.core_out <= pend; fb <= pend;
            end
        end else begin
            bus.core_busy <= stuck;
        end
    end

    logic [7:0]  q_data[$];
    logic        q_last[$];
    int          n_rst = 0, n_load = 0, n_err = 0;
    logic [63:0] rst_in = '0, load_in = '0;
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            q_data.push_back(bus.m_data);
            q_last.push_back(bus.m_last);
        end
        if (bus.core_reset) begin n_rst++; rst_in = bus.core_in; end
        if (bus.core_load) begin n_load++; load_in = bus.core_in; end
        if (err) n_err++;
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int t = 0;
        bus.s_data = b; bus.s_valid = 1'b1; bus.s_last = last;
        @(negedge clk);
        while (!bus.s_ready && t < 200) begin @(negedge clk); t++; end
        if (!bus.s_ready) begin
            checks++; errors++;
            $display("FAIL send_byte: s_ready got 0 after %0d cycles, expected 1", t);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] v, input int nb, input logic last_at_end);
        for (int i = 0; i < nb; i++) send_byte(v[63-8*i -: 8], last_at_end && (i == nb - 1));
    endtask

    task automatic pulse_start();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int target);
        int t = 0;
        while (q_data.size() < target && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (q_data.size() < target) begin
            errors++;
            $display("FAIL wait_bytes: got %0d bytes, expected %0d", q_data.size(), target);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_mvalid();
        int t = 0;
        @(negedge clk);
        while (!bus.m_valid && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!bus.m_valid) begin errors++; $display("FAIL wait_mvalid: m_valid got 0, expected 1"); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_ready, bus.m_valid, bus.m_last, bus.core_reset, bus.core_load, busy, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {bus.s_ready, bus.m_valid, bus.m_last, bus.core_reset, bus.core_load, busy, err});
        end
        checks++;
        if (bus.core_in !== 64'h0) begin errors++; $display("FAIL reset_core_in: got %h, expected 0", bus.core_in); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic();
        int b0 = q_data.size();
        int r0 = n_rst;
        int l0 = n_load;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        wait_bytes(b0 + 8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[b0+i] !== C1[63-8*i -: 8] || q_last[b0+i] !== 1'b0) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h last %b, expected %h last 0", i, q_data[b0+i], q_last[b0+i], C1[63-8*i -: 8]);
            end
        end
        checks++;
        if (n_rst - r0 !== 1 || n_load - l0 !== 1) begin
            errors++;
            $display("FAIL basic_strobes: got reset %0d load %0d cycles, expected 1 and 1", n_rst - r0, n_load - l0);
        end
        checks++;
        if (rst_in !== IV1) begin errors++; $display("FAIL basic_iv: got %h, expected %h", rst_in, IV1); end
        checks++;
        if (load_in !== P1) begin errors++; $display("FAIL basic_block: got %h, expected %h", load_in, P1); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, expected 1", busy); end
    endtask

    task automatic test_chain();
        int b0 = q_data.size();
        send_block(P2, 8, 1'b1);
        wait_bytes(b0 + 8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[b0+i] !== C2[63-8*i -: 8] || q_last[b0+i] !== (i == 7)) begin
                errors++;
                $display("FAIL chain_byte%0d: got %h last %b, expected %h last %b", i, q_data[b0+i], q_last[b0+i], C2[63-8*i -: 8], (i == 7));
            end
        end
        idle_cycles(3);
        checks++;
        if (busy !== 1'b0 || q_data.size() !== b0 + 8) begin
            errors++;
            $display("FAIL chain_end: got busy %b bytes %0d, expected busy 0 bytes %0d", busy, q_data.size(), b0 + 8);
        end
    endtask

    task automatic test_partial();
        int b0 = q_data.size();
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        send_block(PP, 3, 1'b1);
        wait_bytes(b0 + 11);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_data[b0+8+i] !== C2[63-8*i -: 8] || q_last[b0+8+i] !== (i == 2)) begin
                errors++;
                $display("FAIL partial_byte%0d: got %h last %b, expected %h last %b", i, q_data[b0+8+i], q_last[b0+8+i], C2[63-8*i -: 8], (i == 2));
            end
        end
        checks++;
        if (load_in !== PP) begin errors++; $display("FAIL partial_pad: got %h, expected %h", load_in, PP); end
        idle_cycles(20);
        checks++;
        if (q_data.size() !== b0 + 11 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_end: got bytes %0d busy %b, expected bytes %0d busy 0", q_data.size(), busy, b0 + 11);
        end
    endtask

    task automatic test_backpressure();
        int b0 = q_data.size();
        logic [7:0] held;
        bus.m_ready = 1'b0;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        wait_mvalid();
        @(posedge clk); #1; bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1; bus.m_ready = 1'b0;
        @(negedge clk);
        held = bus.m_data;
        checks++;
        if (held !== 8'hf1) begin errors++; $display("FAIL bp_held: got %h, expected f1", held); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.m_data !== held || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got data %h valid %b s_ready %b, expected %h 1 0", i, bus.m_data, bus.m_valid, bus.s_ready, held);
            end
        end
        @(posedge clk); #1; bus.m_ready = 1'b1;
        wait_bytes(b0 + 8);
        idle_cycles(4);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[b0+i] !== C1[63-8*i -: 8]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h, expected %h", i, q_data[b0+i], C1[63-8*i -: 8]);
            end
        end
        checks++;
        if (q_data.size() !== b0 + 8) begin errors++; $display("FAIL bp_count: got %0d, expected %0d", q_data.size(), b0 + 8); end
    endtask

    task automatic test_abort();
        int b0 = q_data.size();
        int r0 = n_rst;
        int l0 = n_load;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        idle_cycles(1);
        pulse_start();
        send_block(IV2, 8, 1'b0);
        send_block(P3, 8, 1'b0);
        wait_bytes(b0 + 8);
        idle_cycles(10);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[b0+i] !== C3[63-8*i -: 8]) begin
                errors++;
                $display("FAIL abort_byte%0d: got %h, expected %h", i, q_data[b0+i], C3[63-8*i -: 8]);
            end
        end
        checks++;
        if (q_data.size() !== b0 + 8 || n_rst - r0 !== 2 || n_load - l0 !== 2) begin
            errors++;
            $display("FAIL abort_counts: got bytes %0d resets %0d loads %0d, expected %0d 2 2", q_data.size(), n_rst - r0, n_load - l0, b0 + 8);
        end
    endtask

    task automatic test_start_gating();
        int b0 = q_data.size();
        int l0 = n_load;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.core_load !== 1'b0) begin errors++; $display("FAIL gate_core_load: got %b, expected 0", bus.core_load); end
        @(posedge clk); #1; start = 1'b0;
        send_block(IV2, 2, 1'b0);
        start = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hff;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL gate_s_ready: got %b, expected 0", bus.s_ready); end
        @(posedge clk); #1; start = 1'b0; bus.s_valid = 1'b0;
        send_block(IV2, 8, 1'b0);
        send_block(P3, 8, 1'b1);
        wait_bytes(b0 + 8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[b0+i] !== C3[63-8*i -: 8] || q_last[b0+i] !== (i == 7)) begin
                errors++;
                $display("FAIL gate_byte%0d: got %h last %b, expected %h last %b", i, q_data[b0+i], q_last[b0+i], C3[63-8*i -: 8], (i == 7));
            end
        end
        checks++;
        if (n_load - l0 !== 1) begin errors++; $display("FAIL gate_loads: got %0d, expected 1", n_load - l0); end
    endtask

    task automatic test_iv_err();
        int e0 = n_err;
        idle_cycles(2);
        pulse_start();
        send_byte(8'h6a, 1'b0);
        send_byte(8'ha0, 1'b0);
        send_byte(8'h37, 1'b1);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL iv_err_pulse: got err %b busy %b, expected err 1 busy 0", err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || n_err - e0 !== 1) begin
            errors++;
            $display("FAIL iv_err_width: got err %b count %0d, expected err 0 count 1", err, n_err - e0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int t = 0;
        stuck = 1'b1;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        while (!err && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t < BT || t > BT + 3) begin
            errors++;
            $display("FAIL timeout_cycles: got err after %0d cycles, expected %0d..%0d", t, BT, BT + 3);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy %b, expected 0", busy); end
        stuck = 1'b0;
        @(posedge clk); #1;
        idle_cycles(3);
    endtask

    task automatic test_reset_emit();
        int b0 = q_data.size();
        bus.m_ready = 1'b0;
        pulse_start();
        send_block(IV1, 8, 1'b0);
        send_block(P1, 8, 1'b0);
        wait_mvalid();
        @(posedge clk); #1; reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_ready, bus.m_valid, bus.m_last, bus.core_reset, bus.core_load, busy, err} !== 7'b0 || bus.core_in !== 64'h0) begin
            errors++;
            $display("FAIL reset_emit: got ctl %b core_in %h, expected 0000000 and 0",
                     {bus.s_ready, bus.m_valid, bus.m_last, bus.core_reset, bus.core_load, busy, err}, bus.core_in);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; bus.m_ready = 1'b1;
        idle_cycles(5);
        checks++;
        if (q_data.size() !== b0) begin errors++; $display("FAIL reset_emit_bytes: got %0d, expected %0d", q_data.size(), b0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_chain();
        test_partial();
        test_backpressure();
        test_abort();
        test_start_gating();
        test_iv_err();
        test_timeout();
        test_reset_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
